// File: rtl/washing_machine_timer_pkg.sv
// -----------------------------------------------------------------------------
// wm_pkg
// Shared definitions for the washing machine phase timer.
//   - Phase index constants in phase-vector order:
//     {drain, spin, rinse, wash_high, wash_low, soak_high, soak_low}
//   - NUM_PHASES : width of the phase vector
//   - phase_bit(): one-hot vector for a phase index
//   - dur_of()   : duration in ticks of a one-hot phase vector (0 becomes 1)
//   - max_int()  : helper for the static counter-width check
// -----------------------------------------------------------------------------
package wm_pkg;

    localparam int NUM_PHASES   = 7;

    localparam int PH_SOAK_LOW  = 0;
    localparam int PH_SOAK_HIGH = 1;
    localparam int PH_WASH_LOW  = 2;
    localparam int PH_WASH_HIGH = 3;
    localparam int PH_RINSE     = 4;
    localparam int PH_SPIN      = 5;
    localparam int PH_DRAIN     = 6;

    function automatic logic [NUM_PHASES-1:0] phase_bit(input int idx);
        return NUM_PHASES'(1) << idx;
    endfunction

    // Non one-hot vectors map to 1; callers only use the result while
    // exactly one phase is active.
    function automatic int dur_of(
        input logic [NUM_PHASES-1:0] p,
        input int soak_low_t,
        input int soak_high_t,
        input int wash_low_t,
        input int wash_high_t,
        input int rinse_t,
        input int spin_t,
        input int drain_t
    );
        int d;
        d = 1;
        if      (p == phase_bit(PH_SOAK_LOW))  d = soak_low_t;
        else if (p == phase_bit(PH_SOAK_HIGH)) d = soak_high_t;
        else if (p == phase_bit(PH_WASH_LOW))  d = wash_low_t;
        else if (p == phase_bit(PH_WASH_HIGH)) d = wash_high_t;
        else if (p == phase_bit(PH_RINSE))     d = rinse_t;
        else if (p == phase_bit(PH_SPIN))      d = spin_t;
        else if (p == phase_bit(PH_DRAIN))     d = drain_t;
        return (d < 1) ? 1 : d;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/wm_tick_gen.sv
// -----------------------------------------------------------------------------
// wm_tick_gen
// Prescaler producing a one-cycle tick every TICK_DIV enabled clk cycles.
//   clk  in  : system clock, rising edge
//   rst  in  : asynchronous, active-high reset
//   clr  in  : synchronous clear of the prescaler (highest priority)
//   en   in  : advance the prescaler this cycle
//   tick out : prescaler is at its terminal count (decoded from the register)
// -----------------------------------------------------------------------------
module wm_tick_gen #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    // A zero-width register is illegal, so TICK_DIV = 1 keeps one bit that
    // never leaves 0 and the tick decode is then permanently true.
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    if (TICK_DIV < 1) begin : g_bad_tick_div
        $error("wm_tick_gen: TICK_DIV must be at least 1");
    end

    logic [PRE_W-1:0] r_pre;

    assign tick = (r_pre == PRE_W'(TICK_DIV - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of always-block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
        end else if (clr) begin
            r_pre <= '0;
        end else if (en) begin
            r_pre <= tick ? '0 : r_pre + 1'b1;
        end
    end

endmodule

// File: rtl/washing_machine_timer.sv
// -----------------------------------------------------------------------------
// washing_machine_timer
// Times the controller's active phase and raises the matching done flag when
// the phase's programmed duration (in ticks of TICK_DIV clk cycles) elapses.
//   clk, rst            in  : clock (rising edge), async active-high reset
//   idle .. drain       in  : one-hot phase outputs of the controller
//   pause               in  : freeze timing while high
//   timer_<phase>       out : level done flag, held until the phase changes
//   phase_err           out : more than one phase input was high last edge
//   elapsed [CNT_W]     out : ticks elapsed in the current phase (saturates)
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module washing_machine_timer
    import wm_pkg::*;
#(
    parameter int TICK_DIV    = 1000,
    parameter int CNT_W       = 16,
    parameter int SOAK_LOW_T  = 10,
    parameter int SOAK_HIGH_T = 20,
    parameter int WASH_LOW_T  = 15,
    parameter int WASH_HIGH_T = 30,
    parameter int RINSE_T     = 10,
    parameter int SPIN_T      = 8,
    parameter int DRAIN_T     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             idle,
    input  logic             soak_low,
    input  logic             soak_high,
    input  logic             wash_low,
    input  logic             wash_high,
    input  logic             rinse,
    input  logic             spin,
    input  logic             drain,
    input  logic             pause,
    output logic             timer_soak_low,
    output logic             timer_soak_high,
    output logic             timer_wash_low,
    output logic             timer_wash_high,
    output logic             timer_rinse,
    output logic             timer_spin,
    output logic             timer_drain,
    output logic             phase_err,
    output logic [CNT_W-1:0] elapsed
);

    localparam int MAX_DUR =
        max_int(max_int(max_int(SOAK_LOW_T, SOAK_HIGH_T), max_int(WASH_LOW_T, WASH_HIGH_T)),
                max_int(max_int(RINSE_T, SPIN_T), max_int(DRAIN_T, 1)));

    // The counter saturates at the phase duration, so it only needs to hold
    // the longest one; it can never wrap.
    if (CNT_W < 1 || CNT_W > 31 || MAX_DUR >= (1 << CNT_W)) begin : g_bad_cnt_w
        $error("washing_machine_timer: CNT_W too narrow for the longest duration");
    end

    logic [NUM_PHASES-1:0] w_p;
    logic [NUM_PHASES-1:0] r_prev_p;
    logic [NUM_PHASES-1:0] r_done;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_dur;
    logic                  r_phase_err;
    logic                  w_entry;
    logic                  w_one_hot;
    logic                  w_multi;
    logic                  w_timing;
    logic                  w_tick;
    logic                  w_unused_idle;

    // idle carries no information beyond "no phase bit set".
    assign w_unused_idle = idle;

    assign w_p       = {drain, spin, rinse, wash_high, wash_low, soak_high, soak_low};
    assign w_entry   = (w_p != r_prev_p);
    assign w_one_hot = ($countones(w_p) == 1);
    assign w_multi   = ($countones(w_p) > 1);
    assign w_dur     = CNT_W'(dur_of(w_p, SOAK_LOW_T, SOAK_HIGH_T, WASH_LOW_T,
                                     WASH_HIGH_T, RINSE_T, SPIN_T, DRAIN_T));
    // Timing runs only in a stable single phase that has not finished yet.
    assign w_timing  = w_one_hot && (r_done == '0) && !w_entry;

    wm_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_entry),
        .en   (w_timing && !pause),
        .tick (w_tick)
    );

    // NOTE: only control/status registers exist here; there is no memory
    // array, so every register gets the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_p    <= '0;
            r_cnt       <= '0;
            r_done      <= '0;
            r_phase_err <= 1'b0;
        end else begin
            // The error flag tracks the sampled vector on every edge,
            // independent of entry edges.
            r_phase_err <= w_multi;
            if (w_entry) begin
                // A phase change beats a simultaneous tick.
                r_prev_p <= w_p;
                r_cnt    <= '0;
                r_done   <= '0;
            end else if (!w_one_hot) begin
                r_cnt    <= '0;
                r_done   <= '0;
            end else if (w_timing && !pause && w_tick) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == w_dur - 1'b1) begin
                    r_done <= w_p;
                end
            end
        end
    end

    assign timer_soak_low  = r_done[PH_SOAK_LOW];
    assign timer_soak_high = r_done[PH_SOAK_HIGH];
    assign timer_wash_low  = r_done[PH_WASH_LOW];
    assign timer_wash_high = r_done[PH_WASH_HIGH];
    assign timer_rinse     = r_done[PH_RINSE];
    assign timer_spin      = r_done[PH_SPIN];
    assign timer_drain     = r_done[PH_DRAIN];
    assign phase_err       = r_phase_err;
    assign elapsed         = r_cnt;

endmodule

// File: tb/tb_washing_machine_timer.sv
// -----------------------------------------------------------------------------
// tb_washing_machine_timer
// Instance A: TICK_DIV=2, SOAK_HIGH_T=3, WASH_HIGH_T=2, DRAIN_T=1.
// Instance B: TICK_DIV=1, DRAIN_T=1.
// Instance A is compared every cycle against a model that counts unpaused
// cycles spent in the current phase; directed edge checks and random phase
// sequences follow.
// -----------------------------------------------------------------------------
module tb_washing_machine_timer;

    localparam int TD = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] p_in;
    logic       pause_in;
    wire  [6:0] a_t;
    wire        a_err;
    wire [15:0] a_el;

    logic [6:0] b_p;
    logic       b_pause;
    wire  [6:0] b_t;
    wire        b_err;
    wire [15:0] b_el;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: phase last sampled, unpaused cycles spent in it, error flag.
    logic [6:0] m_prev;
    int         m_run;
    logic       m_err;
    int         dur_a [7] = '{10, 3, 15, 2, 10, 8, 1};

    always #5 clk = ~clk;

    washing_machine_timer #(
        .TICK_DIV(TD), .CNT_W(16), .SOAK_HIGH_T(3), .WASH_HIGH_T(2), .DRAIN_T(1)
    ) dut_a (
        .clk(clk), .rst(rst), .idle(p_in == 7'd0),
        .soak_low(p_in[0]), .soak_high(p_in[1]), .wash_low(p_in[2]),
        .wash_high(p_in[3]), .rinse(p_in[4]), .spin(p_in[5]), .drain(p_in[6]),
        .pause(pause_in),
        .timer_soak_low(a_t[0]), .timer_soak_high(a_t[1]), .timer_wash_low(a_t[2]),
        .timer_wash_high(a_t[3]), .timer_rinse(a_t[4]), .timer_spin(a_t[5]),
        .timer_drain(a_t[6]), .phase_err(a_err), .elapsed(a_el)
    );

    washing_machine_timer #(
        .TICK_DIV(1), .CNT_W(16), .DRAIN_T(1)
    ) dut_b (
        .clk(clk), .rst(rst), .idle(b_p == 7'd0),
        .soak_low(b_p[0]), .soak_high(b_p[1]), .wash_low(b_p[2]),
        .wash_high(b_p[3]), .rinse(b_p[4]), .spin(b_p[5]), .drain(b_p[6]),
        .pause(b_pause),
        .timer_soak_low(b_t[0]), .timer_soak_high(b_t[1]), .timer_wash_low(b_t[2]),
        .timer_wash_high(b_t[3]), .timer_rinse(b_t[4]), .timer_spin(b_t[5]),
        .timer_drain(b_t[6]), .phase_err(b_err), .elapsed(b_el)
    );

    function automatic int dur_of_p(input logic [6:0] p);
        for (int i = 0; i < 7; i++) begin
            if (p[i]) return dur_a[i];
        end
        return 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev = '0;
        m_run  = 0;
        m_err  = 1'b0;
    endtask

    // Applied at each rising edge with the inputs sampled there.
    task automatic model_edge();
        if (p_in != m_prev) begin
            m_prev = p_in;
            m_run  = 0;
        end else if ($countones(p_in) == 1 && !pause_in && m_run < dur_of_p(p_in) * TD) begin
            m_run++;
        end
        m_err = ($countones(p_in) > 1);
    endtask

    task automatic check_model(input string tag);
        logic [6:0]  exp_t;
        logic [15:0] exp_el;
        exp_t  = '0;
        exp_el = '0;
        if ($countones(m_prev) == 1) begin
            exp_el = 16'(m_run / TD);
            if (m_run >= dur_of_p(m_prev) * TD) exp_t = m_prev;
        end
        chk({tag, "_timers"}, 32'(a_t), 32'(exp_t));
        chk({tag, "_elapsed"}, 32'(a_el), 32'(exp_el));
        chk({tag, "_err"}, 32'(a_err), 32'(m_err));
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    initial begin
        logic [15:0] held_el;
        rst      = 1'b1;
        p_in     = '0;
        pause_in = 1'b0;
        b_p      = '0;
        b_pause  = 1'b0;
        model_reset();

        // Reset state
        #12;
        chk("rst_timers", 32'(a_t), 32'd0);
        chk("rst_elapsed", 32'(a_el), 32'd0);
        chk("rst_err", 32'(a_err), 32'd0);
        chk("rst_b_timers", 32'(b_t), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: soak_high, 3 ticks of 2 cycles
        p_in = 7'b0000010;
        cycle("t1_entry");
        for (int i = 1; i <= 6; i++) begin
            cycle("t1_run");
            if (i == 5) chk("t1_not_yet", 32'(a_t[1]), 32'd0);
        end
        chk("t1_rise", 32'(a_t[1]), 32'd1);
        chk("t1_elapsed3", 32'(a_el), 32'd3);
        chk("t1_others", 32'(a_t & 7'b1111101), 32'd0);

        // 2: controller moves to wash_high at k+7
        p_in = 7'b0001000;
        cycle("t2_entry");
        chk("t2_soak_clear", 32'(a_t[1]), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            cycle("t2_run");
            if (i == 3) chk("t2_not_yet", 32'(a_t[3]), 32'd0);
        end
        chk("t2_rise", 32'(a_t[3]), 32'd1);

        // 3: pause during edges j+2..j+4
        p_in = 7'b0000001;
        cycle("t3_pre");
        p_in = 7'b0001000;
        cycle("t3_entry");
        cycle("t3_j1");
        pause_in = 1'b1;
        held_el  = a_el;
        for (int i = 0; i < 3; i++) begin
            cycle("t3_paused");
            chk("t3_el_hold", 32'(a_el), 32'(held_el));
        end
        pause_in = 1'b0;
        cycle("t3_j5");
        cycle("t3_j6");
        chk("t3_not_at_j6", 32'(a_t[3]), 32'd0);
        cycle("t3_j7");
        chk("t3_rise_j7", 32'(a_t[3]), 32'd1);

        // 4: two phases high
        p_in = 7'b0010001;
        cycle("t4_err");
        chk("t4_err_set", 32'(a_err), 32'd1);
        chk("t4_timers0", 32'(a_t), 32'd0);
        chk("t4_el0", 32'(a_el), 32'd0);
        cycle("t4_err_hold");
        p_in = 7'b0000001;
        cycle("t4_recover");
        chk("t4_err_clr", 32'(a_err), 32'd0);
        chk("t4_el_restart", 32'(a_el), 32'd0);
        cycle("t4_run");
        cycle("t4_run");
        chk("t4_el1", 32'(a_el), 32'd1);

        // 5: async reset between edges
        p_in = 7'b0001000;
        cycle("t5_entry");
        cycle("t5_run");
        cycle("t5_run");
        chk("t5_el_before", 32'(a_el), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("t5_async_timers", 32'(a_t), 32'd0);
        chk("t5_async_el", 32'(a_el), 32'd0);
        chk("t5_async_err", 32'(a_err), 32'd0);
        model_reset();
        #2;
        rst = 1'b0;
        cycle("t5_first_edge");
        for (int i = 1; i <= 4; i++) begin
            cycle("t5_run2");
            if (i == 3) chk("t5_not_yet", 32'(a_t[3]), 32'd0);
        end
        chk("t5_rise", 32'(a_t[3]), 32'd1);

        // 6: instance B, TICK_DIV=1 and DRAIN_T=1
        b_p = 7'b1000000;
        cycle("t6_a_bg");
        chk("t6_b_entry", 32'(b_t), 32'd0);
        cycle("t6_a_bg");
        chk("t6_b_drain", 32'(b_t), 32'b1000000);
        chk("t6_b_el", 32'(b_el), 32'd1);
        b_p = 7'd0;
        for (int i = 0; i < 20; i++) begin
            cycle("t6_a_bg");
            chk("t6_b_idle", 32'(b_t), 32'd0);
        end

        // Random phase sequences against the model
        for (int s = 0; s < 60; s++) begin
            int sel;
            int len;
            sel = $urandom_range(0, 9);
            if (sel < 2) begin
                p_in = '0;
            end else if (sel == 2) begin
                int i0;
                int i1;
                i0 = $urandom_range(0, 6);
                i1 = (i0 + $urandom_range(1, 6)) % 7;
                p_in = 7'(1 << i0) | 7'(1 << i1);
            end else begin
                p_in = 7'(1 << $urandom_range(0, 6));
            end
            len = $urandom_range(1, 30);
            for (int c = 0; c < len; c++) begin
                pause_in = ($urandom_range(0, 3) == 0);
                cycle("rnd");
            end
        end
        pause_in = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/washing_machine_timer.md
Name: washing_machine_timer

Overview:
- Phase-duration timer that sits on the other end of the `washing_machine` controller's timer interface.
- It watches the controller's one-hot phase outputs and times the active phase. When the programmed duration elapses, it raises the matching `timer_*` done input back to the controller.
- It replaces the hand-driven `timer_*` stimulus and closes the controller loop in the top-level design.

Parameters:
- TICK_DIV, 1000: clk cycles per timer tick, minimum 1.
- CNT_W, 16: width of the elapsed-tick counter.
- SOAK_LOW_T, 10: soak_low duration in ticks.
- SOAK_HIGH_T, 20: soak_high duration in ticks.
- WASH_LOW_T, 15: wash_low duration in ticks.
- WASH_HIGH_T, 30: wash_high duration in ticks.
- RINSE_T, 10: rinse duration in ticks.
- SPIN_T, 8: spin duration in ticks.
- DRAIN_T, 5: drain duration in ticks.
- Any duration of 0 is treated as 1.

Ports:
- clk in 1: system clock, rising edge.
- rst in 1: reset; asynchronous, active-high.
- idle, soak_low, soak_high, wash_low, wash_high, rinse, spin, drain in 1 each: controller phase outputs.
- pause in 1: freeze timing while high (door open or stop request).
- timer_soak_low, timer_soak_high, timer_wash_low, timer_wash_high, timer_rinse, timer_spin, timer_drain out 1 each: phase-done flags to the controller.
- phase_err out 1: more than one phase input is high.
- elapsed out CNT_W: ticks elapsed in the current phase.

Behaviour:
- Phase vector P = {drain, spin, rinse, wash_high, wash_low, soak_high, soak_low}, 7 bits.
- `idle` counts only as "no active phase".
- Reset (async, any time): prescaler, counter and prev_P are 0. All `timer_*`, phase_err and elapsed are 0.
- After reset release with a phase already high, the phase is seen as newly entered (prev_P = 0) and timing restarts from 0.
- Registered state:
  - prev_P
  - prescaler pre, width clog2(TICK_DIV)
  - cnt, CNT_W bits, driven on elapsed
  - done vector D, 7 bits, driven directly onto `timer_*`
- Entry edge: any clk edge where P != prev_P. At that edge: prev_P <= P, pre <= 0, cnt <= 0, D <= 0. All other logic is ignored that cycle.
- States, derived per cycle from P:
  - IDLE: P == 0. pre, cnt and D held at 0.
  - ERR: popcount(P) > 1. phase_err <= 1; pre, cnt and D held at 0.
  - TIMING: exactly one bit set and D == 0.
  - DONE: D != 0.
- phase_err is registered and clears on the first edge with popcount(P) <= 1.
- tick = (pre == TICK_DIV-1). When TICK_DIV = 1, tick is always 1.
- In TIMING with pause = 0:
  - pre <= tick ? 0 : pre+1.
  - On tick, cnt <= cnt+1.
  - On tick with cnt == DUR(P)-1: D <= P, and cnt reaches DUR.
- Latency: D rises exactly DUR*TICK_DIV clk edges after the entry edge, with no pause in between.
- pause = 1: pre, cnt and D all hold.
  - Pause stretches the phase by exactly the number of paused cycles.
  - Pause does not clear D.
- DONE: D, and therefore the `timer_*` output, stays high as a level until the next entry edge. cnt saturates at DUR.
- The controller's phase change clears D at that entry edge. The `timer_*` output is low in the first cycle the new phase is sampled.
- Simultaneous phase change and tick: the entry edge wins, and cnt restarts at 0.
- CNT_W must hold the maximum duration; this is a static check. cnt never wraps.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package `wm_pkg`:
  - phase index constants 0-6 in P order
  - NUM_PHASES = 7
  - function dur_of(P) mapping a one-hot P to its duration parameter, with the 0 → 1 rule applied
- One sub-module: `wm_tick_gen` (TICK_DIV prescaler).
  - Inputs: clk, rst, clr, en.
  - Output: tick.
  - The main block holds the phase tracking, counter and done logic.

Test Plan (TICK_DIV = 2, SOAK_HIGH_T = 3, WASH_HIGH_T = 2, DRAIN_T = 1; others default):
1. Reset, then soak_high = 1 sampled at edge k:
   - timer_soak_high rises at edge k+6 and stays high.
   - elapsed = 3.
   - All other `timer_*` stay 0.
2. Controller-loop step: at edge k+7, soak_high drops and wash_high = 1:
   - timer_soak_high is 0 from edge k+7.
   - timer_wash_high rises at edge k+11.
3. Pause: wash_high entered at edge j, pause = 1 during edges j+2 to j+4 (3 cycles):
   - timer_wash_high rises at edge j+7, not j+4.
   - elapsed holds its value during the pause.
4. Error: soak_low and rinse both high:
   - phase_err = 1 next edge.
   - All `timer_*` = 0 and elapsed = 0.
   - Dropping rinse clears phase_err, and soak_low timing starts from 0.
5. Async reset asserted mid-phase, between clock edges (wash_high, elapsed = 1):
   - All outputs are 0 immediately, with no clock edge.
   - After release with wash_high still high, timer_wash_high rises 4 edges after the first sampling edge.
6. DRAIN_T = 1 and TICK_DIV = 1 (separate instance):
   - timer_drain rises 1 edge after the entry edge.
   - idle-only input keeps all `timer_*` at 0 indefinitely.
